// File: rtl/clock_control.sv
// Clock-enable generator for a single-step / free-run / halt machine.
// Produces one-cycle o_clk_en pulses from a debounced step button or a run-mode prescaler.
module clock_control #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned DIV_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_run,
   input  logic                 i_step_btn,
   input  logic [DIV_WIDTH-1:0] i_div,
   input  logic                 i_halt,
   output logic                 o_clk_en,
   output logic                 o_running,
   output logic                 o_halted,
   output logic [15:0]          o_pulse_count
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_STEP   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   logic                 run_s1, run_s2;
   logic                 stp_s1, stp_s2;
   logic                 deb_level;
   logic [CNT_W-1:0]     deb_cnt;
   logic                 deb_mismatch;
   logic                 deb_fire;
   logic                 step_evt;

   state_t               state, state_nxt;
   logic [DIV_WIDTH-1:0] presc, presc_nxt;
   logic                 clk_en_nxt;
   logic [15:0]          pulse_cnt_nxt;

   // Two-flop synchronizers for the asynchronous switch and button
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_s1 <= 1'b0;
         run_s2 <= 1'b0;
         stp_s1 <= 1'b0;
         stp_s2 <= 1'b0;
      end else begin
         run_s1 <= i_run;
         run_s2 <= run_s1;
         stp_s1 <= i_step_btn;
         stp_s2 <= stp_s1;
      end
   end

   // Level is accepted on the Nth consecutive cycle of disagreement
   assign deb_mismatch = stp_s2 ^ deb_level;
   assign deb_fire     = deb_mismatch && (deb_cnt == DEB_LAST);
   assign step_evt     = deb_fire && stp_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_level <= 1'b0;
         deb_cnt   <= '0;
      end else if (!deb_mismatch) begin
         deb_cnt <= '0;
      end else if (deb_fire) begin
         deb_level <= stp_s2;
         deb_cnt   <= '0;
      end else begin
         deb_cnt <= CNT_W'(deb_cnt + 1'b1);
      end
   end

   // Next-state, prescaler and pulse decision; halt overrides everything
   always_comb begin
      state_nxt  = state;
      presc_nxt  = presc;
      clk_en_nxt = 1'b0;
      case (state)
         ST_STEP: begin
            if (run_s2) begin
               state_nxt = ST_RUN;
               presc_nxt = '0;
            end else if (step_evt) begin
               clk_en_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (!run_s2) begin
               state_nxt = ST_STEP;
            end else if (presc >= i_div) begin
               clk_en_nxt = 1'b1;
               presc_nxt  = '0;
            end else begin
               presc_nxt = DIV_WIDTH'(presc + 1'b1);
            end
         end
         ST_HALTED: begin
            state_nxt = ST_HALTED;
         end
         default: begin
            state_nxt = ST_STEP;
         end
      endcase
      if (i_halt) begin
         state_nxt  = ST_HALTED;
         clk_en_nxt = 1'b0;
      end
      pulse_cnt_nxt = clk_en_nxt ? 16'(o_pulse_count + 1'b1) : o_pulse_count;
   end

   // State, prescaler and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_STEP;
         presc         <= '0;
         o_clk_en      <= 1'b0;
         o_running     <= 1'b0;
         o_halted      <= 1'b0;
         o_pulse_count <= '0;
      end else begin
         state         <= state_nxt;
         presc         <= presc_nxt;
         o_clk_en      <= clk_en_nxt;
         o_running     <= (state_nxt == ST_RUN);
         o_halted      <= (state_nxt == ST_HALTED);
         o_pulse_count <= pulse_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_clock_control.sv
// Directed self-checking bench for clock_control (default parameters).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_clock_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_run;
   logic       i_step_btn;
   logic [7:0] i_div;
   logic       i_halt;
   logic       o_clk_en;
   logic       o_running;
   logic       o_halted;
   logic [15:0] o_pulse_count;

   int n_cmp = 0;
   int n_bad = 0;

   clock_control dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_run        (i_run),
      .i_step_btn   (i_step_btn),
      .i_div        (i_div),
      .i_halt       (i_halt),
      .o_clk_en     (o_clk_en),
      .o_running    (o_running),
      .o_halted     (o_halted),
      .o_pulse_count(o_pulse_count)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reset with idle inputs; returns 1 unit after a rising edge
   task automatic do_reset();
      i_run = 1'b0; i_step_btn = 1'b0; i_halt = 1'b0; i_div = 8'd0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_run = 1'b1; i_step_btn = 1'b1; i_halt = 1'b0; i_div = 8'd0;
      #2;
      n_cmp++;
      if ({o_clk_en, o_running, o_halted, o_pulse_count} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got en=%b run=%b halt=%b cnt=%0h, expected all 0",
                  o_clk_en, o_running, o_halted, o_pulse_count);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({o_clk_en, o_running, o_halted, o_pulse_count} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_held: got en=%b run=%b halt=%b cnt=%0h, expected all 0",
                  o_clk_en, o_running, o_halted, o_pulse_count);
      end
   endtask

   task automatic test_step_clean();
      do_reset();
      repeat (3) @(posedge clk);
      #1 i_step_btn = 1'b1;
      for (int e = 0; e <= 9; e++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== (e == 5)) begin
            n_bad++;
            $display("FAIL step_clean_en edge %0d: got %b expected %b", e, o_clk_en, (e == 5));
         end
      end
      n_cmp++;
      if (o_pulse_count !== 16'd1 || o_running !== 1'b0) begin
         n_bad++;
         $display("FAIL step_clean_count: got cnt=%0h run=%b expected cnt=1 run=0",
                  o_pulse_count, o_running);
      end
   endtask

   task automatic test_bounce();
      logic [3:0] pat;
      do_reset();
      repeat (3) @(posedge clk);
      pat = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         #0 i_step_btn = pat[i];
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_toggle %0d: got %b expected 0", i, o_clk_en);
         end
      end
      i_step_btn = 1'b1;
      for (int e = 0; e <= 9; e++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== (e == 5)) begin
            n_bad++;
            $display("FAIL bounce_hold edge %0d: got %b expected %b", e, o_clk_en, (e == 5));
         end
      end
      i_step_btn = 1'b0;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_release edge %0d: got %b expected 0", e, o_clk_en);
         end
      end
      n_cmp++;
      if (o_pulse_count !== 16'd1) begin
         n_bad++;
         $display("FAIL bounce_count: got %0h expected 1", o_pulse_count);
      end
   endtask

   task automatic test_run();
      do_reset();
      i_div = 8'd3; i_run = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      n_cmp++;
      if (o_running !== 1'b0) begin
         n_bad++;
         $display("FAIL run_sync_delay: got running=%b expected 0", o_running);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (o_running !== 1'b1 || o_clk_en !== 1'b0) begin
         n_bad++;
         $display("FAIL run_entry: got running=%b en=%b expected 1/0", o_running, o_clk_en);
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== (k % 4 == 0)) begin
            n_bad++;
            $display("FAIL run_div3 entry+%0d: got %b expected %b", k, o_clk_en, (k % 4 == 0));
         end
      end
      n_cmp++;
      if (o_pulse_count !== 16'd4) begin
         n_bad++;
         $display("FAIL run_div3_count: got %0h expected 4", o_pulse_count);
      end
      i_div = 8'd0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== 1'b1) begin
            n_bad++;
            $display("FAIL run_div0 cycle %0d: got %b expected 1", k, o_clk_en);
         end
      end
      n_cmp++;
      if (o_pulse_count !== 16'd12) begin
         n_bad++;
         $display("FAIL run_div0_count: got %0h expected c", o_pulse_count);
      end
   endtask

   task automatic test_div_change();
      do_reset();
      i_div = 8'd7; i_run = 1'b1;
      repeat (3) @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== 1'b0) begin
            n_bad++;
            $display("FAIL divchg_pre entry+%0d: got %b expected 0", k, o_clk_en);
         end
      end
      i_div = 8'd2;
      for (int k = 6; k <= 12; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== (k % 3 == 0)) begin
            n_bad++;
            $display("FAIL divchg_post entry+%0d: got %b expected %b", k, o_clk_en, (k % 3 == 0));
         end
      end
   endtask

   task automatic test_discard();
      do_reset();
      i_div = 8'd255; i_run = 1'b1;
      repeat (3) @(posedge clk);
      #1 i_step_btn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k == 10) i_run = 1'b0;
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== 1'b0) begin
            n_bad++;
            $display("FAIL discard cycle %0d: got %b expected 0", k, o_clk_en);
         end
      end
      n_cmp++;
      if (o_running !== 1'b0 || o_pulse_count !== 16'd0) begin
         n_bad++;
         $display("FAIL discard_end: got running=%b cnt=%0h expected 0/0", o_running, o_pulse_count);
      end
   endtask

   task automatic test_halt();
      do_reset();
      i_div = 8'd3; i_run = 1'b1;
      repeat (3) @(posedge clk);
      repeat (3) @(posedge clk);
      #1 i_halt = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (o_clk_en !== 1'b0 || o_halted !== 1'b1 || o_running !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_override: got en=%b halted=%b running=%b expected 0/1/0",
                  o_clk_en, o_halted, o_running);
      end
      i_halt = 1'b0;
      for (int k = 0; k < 30; k++) begin
         i_run      = (k < 5) ? 1'b0 : ((k < 10) ? 1'b1 : 1'b0);
         i_step_btn = (k >= 12 && k < 24);
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== 1'b0 || o_halted !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_stuck cycle %0d: got en=%b halted=%b expected 0/1", k, o_clk_en, o_halted);
         end
      end
      n_cmp++;
      if (o_pulse_count !== 16'd0) begin
         n_bad++;
         $display("FAIL halt_count: got %0h expected 0", o_pulse_count);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_clk_en, o_running, o_halted, o_pulse_count} !== 19'd0) begin
         n_bad++;
         $display("FAIL halt_async_reset: got en=%b run=%b halt=%b cnt=%0h expected all 0",
                  o_clk_en, o_running, o_halted, o_pulse_count);
      end
      i_run = 1'b0; i_step_btn = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 i_step_btn = 1'b1;
      for (int e = 0; e <= 7; e++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_clk_en !== (e == 5) || o_halted !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_then_step edge %0d: got en=%b halted=%b expected %b/0",
                     e, o_clk_en, o_halted, (e == 5));
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      i_div = 8'd0; i_run = 1'b1;
      repeat (3) @(posedge clk);
      repeat (65535) @(posedge clk);
      #1;
      n_cmp++;
      if (o_pulse_count !== 16'hFFFF || o_clk_en !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_preset: got cnt=%0h en=%b expected ffff/1", o_pulse_count, o_clk_en);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (o_pulse_count !== 16'h0000) begin
         n_bad++;
         $display("FAIL wrap_rollover: got %0h expected 0", o_pulse_count);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (o_clk_en !== 1'b0 || o_running !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_midpulse_reset: got en=%b running=%b expected 0/0", o_clk_en, o_running);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_step_clean();
      test_bounce();
      test_run();
      test_div_change();
      test_discard();
      test_halt();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
